// File: rtl/ring_router.sv
// Ring-network router for one CGRA tile: forwards through-traffic, ejects local
// packets to the PE and injects PE packets from a FIFO with bounded-fair arbitration.
module ring_router #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 2,
    parameter int DEST_LSB  = 4,
    parameter int RANK      = 0,
    parameter int INJ_DEPTH = 4,
    parameter int FAIR_N    = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             ring_in_valid,
    input  logic [DATA_W-1:0]                ring_in_data,
    output logic                             ring_in_ready,
    output logic                             ring_out_valid,
    output logic [DATA_W-1:0]                ring_out_data,
    input  logic                             ring_out_ready,
    input  logic                             pe_in_valid,
    input  logic [DATA_W-1:0]                pe_in_data,
    output logic                             pe_in_ready,
    output logic                             pe_out_valid,
    output logic [DATA_W-1:0]                pe_out_data,
    input  logic                             pe_out_ready,
    output logic [$clog2(INJ_DEPTH+1)-1:0]   inj_level
);

    localparam int SRC_LSB = DEST_LSB + ADDR_W;
    localparam int PTR_W   = $clog2(INJ_DEPTH);
    localparam int LVL_W   = $clog2(INJ_DEPTH + 1);
    localparam int CNT_W   = $clog2(FAIR_N + 1);
    localparam logic [ADDR_W-1:0] MY_ADDR  = ADDR_W'(RANK);
    localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(INJ_DEPTH);
    localparam logic [CNT_W-1:0]  FAIR_MAX = CNT_W'(FAIR_N);

    logic [DATA_W-1:0] fifo_mem [INJ_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  fifo_cnt;
    logic [CNT_W-1:0]  fair_cnt;

    logic              ring_free, pe_free, in_local;
    logic              fifo_empty, fifo_full, fair_hit;
    logic              fwd_pending, inj_grant, fwd_fire, eject_fire, fifo_wr;
    logic [DATA_W-1:0] inj_pkt;

    always_comb begin
        ring_free   = !ring_out_valid || ring_out_ready;
        pe_free     = !pe_out_valid || pe_out_ready;
        in_local    = ring_in_data[DEST_LSB +: ADDR_W] == MY_ADDR;
        fifo_empty  = fifo_cnt == '0;
        fifo_full   = fifo_cnt == FULL_LVL;
        fair_hit    = fair_cnt == FAIR_MAX;
        fwd_pending = ring_in_valid && !in_local;
        inj_grant   = ring_free && !fifo_empty && (!fwd_pending || fair_hit);
        fwd_fire    = fwd_pending && ring_free && !inj_grant;
        eject_fire  = ring_in_valid && in_local && pe_free;
        fifo_wr     = pe_in_valid && !fifo_full;
        // Ready assumes a valid packet is present, so it never depends on ring_in_valid
        ring_in_ready = in_local ? pe_free : (ring_free && !(!fifo_empty && fair_hit));
        pe_in_ready   = !fifo_full;
        inj_level     = fifo_cnt;
        inj_pkt       = fifo_mem[rd_ptr];
        inj_pkt[SRC_LSB +: ADDR_W] = MY_ADDR;
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) fifo_mem[wr_ptr] <= pe_in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_cnt       <= '0;
            fair_cnt       <= '0;
            ring_out_valid <= 1'b0;
            ring_out_data  <= '0;
            pe_out_valid   <= 1'b0;
            pe_out_data    <= '0;
        end else begin
            if (fifo_wr)   wr_ptr <= wr_ptr + PTR_W'(1);
            if (inj_grant) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({fifo_wr, inj_grant})
                2'b10:   fifo_cnt <= fifo_cnt + LVL_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - LVL_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase

            if (inj_grant || fifo_empty)  fair_cnt <= '0;
            else if (fwd_fire && !fair_hit) fair_cnt <= fair_cnt + CNT_W'(1);

            if (fwd_fire) begin
                ring_out_valid <= 1'b1;
                ring_out_data  <= ring_in_data;
            end else if (inj_grant) begin
                ring_out_valid <= 1'b1;
                ring_out_data  <= inj_pkt;
            end else if (ring_out_ready) begin
                ring_out_valid <= 1'b0;
            end

            if (eject_fire) begin
                pe_out_valid <= 1'b1;
                pe_out_data  <= ring_in_data;
            end else if (pe_out_ready) begin
                pe_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ring_router.sv
// Directed self-checking bench for ring_router with default geometry (RANK 0,
// dest in bits [5:4], src in bits [7:6]).
module tb_ring_router;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 2;
    localparam int DEST_LSB  = 4;
    localparam int RANK      = 0;
    localparam int INJ_DEPTH = 4;
    localparam int FAIR_N    = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ring_in_valid, ring_in_ready;
    logic [DATA_W-1:0] ring_in_data;
    logic              ring_out_valid, ring_out_ready;
    logic [DATA_W-1:0] ring_out_data;
    logic              pe_in_valid, pe_in_ready;
    logic [DATA_W-1:0] pe_in_data;
    logic              pe_out_valid, pe_out_ready;
    logic [DATA_W-1:0] pe_out_data;
    logic [2:0]        inj_level;

    int n_checks = 0;
    int n_fail   = 0;

    logic       fair_rdy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] fair_out [6] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h22, 8'h14};

    always #5 clk = ~clk;

    ring_router #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEST_LSB(DEST_LSB),
        .RANK(RANK), .INJ_DEPTH(INJ_DEPTH), .FAIR_N(FAIR_N)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ring_in_valid(ring_in_valid), .ring_in_data(ring_in_data), .ring_in_ready(ring_in_ready),
        .ring_out_valid(ring_out_valid), .ring_out_data(ring_out_data), .ring_out_ready(ring_out_ready),
        .pe_in_valid(pe_in_valid), .pe_in_data(pe_in_data), .pe_in_ready(pe_in_ready),
        .pe_out_valid(pe_out_valid), .pe_out_data(pe_out_data), .pe_out_ready(pe_out_ready),
        .inj_level(inj_level)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic acc;
        int   k;
        int   pushed;

        rst_n = 1'b0;
        ring_in_valid = 1'b0; ring_in_data = '0; ring_out_ready = 1'b1;
        pe_in_valid = 1'b0; pe_in_data = '0; pe_out_ready = 1'b1;
        #12;
        check("rst_ring_valid", ring_out_valid, 0);
        check("rst_pe_valid", pe_out_valid, 0);
        check("rst_ring_data", ring_out_data, 0);
        check("rst_level", inj_level, 0);
        check("rst_pe_in_ready", pe_in_ready, 1);
        rst_n = 1'b1;
        tick();

        // Ejection with free pe_out, then with a stalled PE
        ring_in_data = 8'h0A; ring_in_valid = 1'b1; #1;
        check("ej_ready", ring_in_ready, 1);
        tick();
        ring_in_valid = 1'b0;
        check("ej_valid", pe_out_valid, 1);
        check("ej_data", pe_out_data, 8'h0A);
        check("ej_no_ring", ring_out_valid, 0);
        pe_out_ready = 1'b0; ring_in_data = 8'h8A; ring_in_valid = 1'b1; #1;
        for (int i = 0; i < 2; i++) begin
            check("ej_blocked", ring_in_ready, 0);
            check("ej_hold", pe_out_data, 8'h0A);
            tick();
        end
        pe_out_ready = 1'b1; #1;
        check("ej_unblocked", ring_in_ready, 1);
        tick();
        ring_in_valid = 1'b0;
        check("ej2_valid", pe_out_valid, 1);
        check("ej2_data", pe_out_data, 8'h8A);
        tick();
        check("ej_drained", pe_out_valid, 0);

        // Forward, then inject on an idle ring
        ring_in_data = 8'h25; ring_in_valid = 1'b1; #1;
        check("fwd_ready", ring_in_ready, 1);
        tick();
        ring_in_valid = 1'b0;
        check("fwd_valid", ring_out_valid, 1);
        check("fwd_data", ring_out_data, 8'h25);
        check("fwd_no_eject", pe_out_valid, 0);
        tick();
        check("fwd_drained", ring_out_valid, 0);
        pe_in_data = 8'hF7; pe_in_valid = 1'b1; #1;
        check("inj_pe_ready", pe_in_ready, 1);
        tick();
        pe_in_valid = 1'b0;
        check("inj_level1", inj_level, 1);
        check("inj_not_yet", ring_out_valid, 0);
        tick();
        check("inj_valid", ring_out_valid, 1);
        check("inj_data", ring_out_data, 8'h37);
        check("inj_level0", inj_level, 0);
        tick();

        // Fairness: three forwards while injection waits, then the injection
        k = 0;
        ring_in_valid = 1'b1; ring_in_data = 8'h10;
        pe_in_data = 8'hE2; pe_in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            check("fair_ready", ring_in_ready, fair_rdy[c]);
            acc = ring_in_ready;
            tick();
            pe_in_valid = 1'b0;
            if (acc) k++;
            ring_in_data = 8'h10 + 8'(k);
            check("fair_out", ring_out_data, fair_out[c]);
        end
        ring_in_valid = 1'b0;
        tick();
        tick();

        // Backpressure hold while the injection FIFO fills
        ring_out_ready = 1'b0;
        ring_in_data = 8'h3C; ring_in_valid = 1'b1; #1;
        check("bp_first_ready", ring_in_ready, 1);
        tick();
        ring_in_data = 8'h31;
        pushed = 0;
        pe_in_valid = 1'b1; pe_in_data = 8'hE0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_in_ready", ring_in_ready, 0);
            check("bp_valid", ring_out_valid, 1);
            check("bp_data", ring_out_data, 8'h3C);
            check("full_pe_ready", pe_in_ready, c < 4);
            acc = pe_in_ready;
            tick();
            if (acc) pushed++;
            pe_in_data = 8'hE0 + 8'(pushed);
        end
        check("full_level", inj_level, 4);
        check("full_pe_ready_after", pe_in_ready, 0);
        ring_out_ready = 1'b1;
        tick();
        ring_in_valid = 1'b0;
        check("bp_no_loss_valid", ring_out_valid, 1);
        check("bp_no_loss_data", ring_out_data, 8'h31);
        for (int c = 0; c < 10; c++) begin
            #1;
            acc = pe_in_ready;
            tick();
            if (acc) pushed++;
            pe_in_data = 8'hE0 + 8'(pushed);
            check("wrap_order", ring_out_data, 8'h20 + 8'(c));
            check("wrap_valid", ring_out_valid, 1);
            check("wrap_level", inj_level, 3);
        end
        pe_in_valid = 1'b0;
        repeat (5) tick();
        check("drain_level", inj_level, 0);
        check("drain_valid", ring_out_valid, 0);

        // Asynchronous reset with traffic in flight
        ring_out_ready = 1'b0; pe_out_ready = 1'b0;
        ring_in_data = 8'h0A; ring_in_valid = 1'b1;
        tick();
        ring_in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            pe_in_valid = 1'b1;
            pe_in_data  = 8'hA0 + 8'(c);
            tick();
        end
        pe_in_valid = 1'b0;
        check("pre_rst_level", inj_level, 3);
        check("pre_rst_ring_valid", ring_out_valid, 1);
        check("pre_rst_pe_valid", pe_out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_ring_valid", ring_out_valid, 0);
        check("mid_rst_pe_valid", pe_out_valid, 0);
        check("mid_rst_ring_data", ring_out_data, 0);
        check("mid_rst_pe_data", pe_out_data, 0);
        check("mid_rst_level", inj_level, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ring_in_data = 8'h15; ring_in_valid = 1'b1; #1;
        check("post_rst_fwd_ready", ring_in_ready, 1);
        check("post_rst_pe_in_ready", pe_in_ready, 1);
        ring_in_data = 8'h0A; #1;
        check("post_rst_ej_ready", ring_in_ready, 1);
        ring_in_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
